// File: rtl/steer_quad_gen.sv
// steer_quad_gen: converts joystick left/right into an accelerating two-phase quadrature
// steering signal (Gray-coded phase) for the Sprint 1 core, clocked in the clk_6 domain.
module steer_quad_gen #(
   parameter int DIV_SLOW = 22500,
   parameter int DIV_FAST = 5625,
   parameter int DIV_DEC  = 1125,
   parameter int CW       = $clog2(DIV_SLOW + 1)
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   output logic [1:0] steer,
   output logic       moving,
   output logic       step_pulse
);

   generate
      if (DIV_FAST < 1 || DIV_FAST > DIV_SLOW) begin : g_bad_fast
         $error("steer_quad_gen: DIV_FAST must satisfy 1 <= DIV_FAST <= DIV_SLOW");
      end
      if (DIV_DEC < 0 || DIV_DEC >= DIV_SLOW) begin : g_bad_dec
         $error("steer_quad_gen: DIV_DEC must satisfy 0 <= DIV_DEC < DIV_SLOW");
      end
      if (CW < $clog2(DIV_SLOW + 1)) begin : g_bad_cw
         $error("steer_quad_gen: CW too narrow to hold DIV_SLOW");
      end
   endgenerate

   localparam int CW1 = CW + 1;

   localparam logic [CW-1:0] SLOW_C  = CW'(DIV_SLOW);
   localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] ZERO_C  = '0;
   localparam logic [CW-1:0] FAST_C  = CW'(DIV_FAST);
   localparam logic [CW:0]   DEC_W   = CW1'(DIV_DEC);
   localparam logic [CW:0]   FAST_W  = CW1'(DIV_FAST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN_R = 2'd1,
      RUN_L = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_R    = 2'd1,
      DIR_L    = 2'd2
   } dir_t;

   logic          l_meta_q, l_s_q;
   logic          r_meta_q, r_s_q;
   dir_t          dir_req;
   dir_t          cur_dir;

   state_t        state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [1:0]    steer_q, steer_d;
   logic          moving_q, moving_d;
   logic          step_q, step_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] period_q, period_d;

   logic [CW:0]   diff;
   logic [CW-1:0] nxt;
   logic          start;

   // Two-flop synchronizers for the asynchronous joystick bits.
   always_ff @(posedge CLK) begin
      if (reset) begin
         l_meta_q <= 1'b0;
         l_s_q    <= 1'b0;
         r_meta_q <= 1'b0;
         r_s_q    <= 1'b0;
      end else begin
         l_meta_q <= left;
         l_s_q    <= l_meta_q;
         r_meta_q <= right;
         r_s_q    <= r_meta_q;
      end
   end

   always_comb begin
      dir_req = DIR_NONE;
      if (r_s_q && !l_s_q) begin
         dir_req = DIR_R;
      end else if (l_s_q && !r_s_q) begin
         dir_req = DIR_L;
      end
   end

   // Next interval, widened by one bit so period - DIV_DEC shows up negative instead of wrapping.
   always_comb begin
      diff = {1'b0, period_q} - DEC_W;
      if (diff[CW] || (diff < FAST_W)) begin
         nxt = FAST_C;
      end else begin
         nxt = diff[CW-1:0];
      end
   end

   always_comb begin
      cur_dir = DIR_NONE;
      if (state_q == RUN_R) begin
         cur_dir = DIR_R;
      end else if (state_q == RUN_L) begin
         cur_dir = DIR_L;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      step_d   = 1'b0;
      start    = 1'b0;

      case (state_q)
         IDLE: begin
            if (dir_req != DIR_NONE) begin
               start = 1'b1;
            end
         end
         RUN_R, RUN_L: begin
            if (dir_req == DIR_NONE) begin
               state_d  = IDLE;
               cnt_d    = ZERO_C;
               period_d = SLOW_C;
            end else if (dir_req != cur_dir) begin
               // Reversal restarts the ramp; it wins over a step due on this same edge.
               start = 1'b1;
            end else if (cnt_q == ZERO_C) begin
               step_d   = 1'b1;
               cnt_d    = nxt - ONE_C;
               period_d = nxt;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = ZERO_C;
            period_d = SLOW_C;
         end
      endcase

      if (start) begin
         state_d  = (dir_req == DIR_R) ? RUN_R : RUN_L;
         step_d   = 1'b1;
         cnt_d    = SLOW_M1;
         period_d = SLOW_C;
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (step_d) begin
         if (state_d == RUN_R) begin
            phase_d = phase_q + 2'd1;
         end else begin
            phase_d = phase_q - 2'd1;
         end
      end

      steer_d = 2'b00;
      case (phase_d)
         2'd0:    steer_d = 2'b00;
         2'd1:    steer_d = 2'b01;
         2'd2:    steer_d = 2'b11;
         default: steer_d = 2'b10;
      endcase

      moving_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= IDLE;
         phase_q  <= 2'd0;
         steer_q  <= 2'b00;
         moving_q <= 1'b0;
         step_q   <= 1'b0;
         cnt_q    <= ZERO_C;
         period_q <= SLOW_C;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         steer_q  <= steer_d;
         moving_q <= moving_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   assign steer      = steer_q;
   assign moving     = moving_q;
   assign step_pulse = step_q;

endmodule

// File: tb/tb_steer_quad_gen.sv
// Bench for steer_quad_gen: directed and randomized joystick segments checked against an
// interval-arithmetic model of the step schedule, plus ramp checks on scaled and default builds.
module tb_steer_quad_gen;

   localparam int SLOW = 8;
   localparam int FAST = 4;
   localparam int DEC  = 2;
   localparam int S2   = 500;
   localparam int F2   = 125;
   localparam int D2   = 25;

   logic       clk = 1'b0;
   logic       reset;
   logic       left, right;
   logic [1:0] steer;
   logic       moving, step_pulse;
   logic       left2, right2;
   logic [1:0] steer2;
   logic       moving2, step_pulse2;
   logic       left3, right3;
   logic [1:0] steer3;
   logic       moving3, step_pulse3;

   always #5 clk = ~clk;

   steer_quad_gen #(.DIV_SLOW(SLOW), .DIV_FAST(FAST), .DIV_DEC(DEC)) dut (
      .CLK(clk), .reset(reset), .left(left), .right(right),
      .steer(steer), .moving(moving), .step_pulse(step_pulse)
   );

   steer_quad_gen #(.DIV_SLOW(S2), .DIV_FAST(F2), .DIV_DEC(D2)) dut_scaled (
      .CLK(clk), .reset(reset), .left(left2), .right(right2),
      .steer(steer2), .moving(moving2), .step_pulse(step_pulse2)
   );

   steer_quad_gen dut_def (
      .CLK(clk), .reset(reset), .left(left3), .right(right3),
      .steer(steer3), .moving(moving3), .step_pulse(step_pulse3)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   logic rst_edge;

   logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   int         step_cyc_q[$];
   logic [1:0] step_val_q[$];
   int         toggle_err = 0;
   logic [1:0] prev_steer = 2'b00;

   int         seg_dir[$];
   int         seg_start[$];
   int         exp_cyc_q[$];
   logic [1:0] exp_q[$];
   int         obs_base;
   int         tog_base;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= reset;
   end

   // Records every step of the main DUT and counts steer changes not matched one-to-one by step_pulse.
   always @(negedge clk) begin
      if (step_pulse === 1'b1) begin
         step_cyc_q.push_back(cyc);
         step_val_q.push_back(steer);
      end
      if (rst_edge === 1'b0) begin
         if (step_pulse === 1'b1) begin
            if ($countones(steer ^ prev_steer) != 1) toggle_err = toggle_err + 1;
         end else if (steer !== prev_steer) begin
            toggle_err = toggle_err + 1;
         end
      end
      prev_steer = steer;
   end

   // Steps for each segment: first one two edges after the inputs are sampled,
   // then intervals SLOW, SLOW-DEC, ... clamped at FAST, until the next segment takes effect.
   function automatic void build_expected(input int slow, input int fast, input int dec);
      int phase;
      int t;
      int lim;
      int k;
      int iv;
      exp_cyc_q.delete();
      exp_q.delete();
      phase = 0;
      for (int i = 0; i < seg_dir.size(); i++) begin
         if (seg_dir[i] == 0) continue;
         t   = seg_start[i] + 2;
         lim = (i + 1 < seg_dir.size()) ? seg_start[i+1] + 2 : t + 1;
         k   = 0;
         while (t < lim) begin
            phase = (phase + seg_dir[i] + 4) % 4;
            exp_cyc_q.push_back(t);
            exp_q.push_back(gray_tab[phase]);
            iv = slow - k * dec;
            if (iv < fast) iv = fast;
            t = t + iv;
            k = k + 1;
         end
      end
   endfunction

   task automatic do_reset();
      right  = 1'b0;
      left   = 1'b0;
      right2 = 1'b0;
      left2  = 1'b0;
      right3 = 1'b0;
      left3  = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      seg_dir.delete();
      seg_start.delete();
      obs_base = step_cyc_q.size();
      tog_base = toggle_err;
   endtask

   // d: 0 none, 1 right, 2 left, 3 both; held for n cycles.
   task automatic apply(input int d, input int n);
      right = (d == 1 || d == 3);
      left  = (d == 2 || d == 3);
      seg_dir.push_back(d == 1 ? 1 : (d == 2 ? -1 : 0));
      seg_start.push_back(cyc + 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      bit found;
      int rst_e;
      n_vec++;
      if (steer !== 2'b00) begin n_err++; $display("FAIL reset_steer got %b want 00", steer); end
      n_vec++;
      if (moving !== 1'b0) begin n_err++; $display("FAIL reset_moving got %b want 0", moving); end
      n_vec++;
      if (step_pulse !== 1'b0) begin n_err++; $display("FAIL reset_step got %b want 0", step_pulse); end
      reset = 1'b0;
      right = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (steer === 2'b11) found = 1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL reset_reach_11 got %b want 11", steer); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rst_e = cyc + 1;
      @(negedge clk);
      n_vec++;
      if (steer !== 2'b00) begin n_err++; $display("FAIL midrun_reset_steer got %b want 00", steer); end
      n_vec++;
      if (moving !== 1'b0) begin n_err++; $display("FAIL midrun_reset_moving got %b want 0", moving); end
      n_vec++;
      if (step_pulse !== 1'b0) begin n_err++; $display("FAIL midrun_reset_step got %b want 0", step_pulse); end
      reset = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (step_pulse === 1'b1) found = 1;
      end
      n_vec++;
      if (!found || cyc != rst_e + 3) begin
         n_err++; $display("FAIL post_reset_latency got edge %0d want %0d", found ? cyc : -1, rst_e + 3);
      end
      n_vec++;
      if (steer !== 2'b01) begin n_err++; $display("FAIL post_reset_steer got %b want 01", steer); end
      right = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_right_hold();
      int want_iv [5] = '{8, 6, 4, 4, 4};
      logic [1:0] want_seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
      int nobs;
      do_reset();
      apply(1, 40);
      n_vec++;
      if (moving !== 1'b1) begin n_err++; $display("FAIL right_hold_moving got %b want 1", moving); end
      apply(0, 10);
      n_vec++;
      if (moving !== 1'b0) begin n_err++; $display("FAIL right_release_moving got %b want 0", moving); end
      build_expected(SLOW, FAST, DEC);
      nobs = step_cyc_q.size() - obs_base;
      n_vec++;
      if (nobs != exp_cyc_q.size()) begin
         n_err++; $display("FAIL right_hold_count got %0d want %0d", nobs, exp_cyc_q.size());
      end
      for (int i = 0; i < exp_cyc_q.size() && i < nobs; i++) begin
         n_vec++;
         if (step_cyc_q[obs_base+i] != exp_cyc_q[i] || step_val_q[obs_base+i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL right_hold_step%0d got edge %0d steer %b want edge %0d steer %b", i,
                     step_cyc_q[obs_base+i], step_val_q[obs_base+i], exp_cyc_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (nobs < 6 || step_cyc_q[obs_base] != seg_start[0] + 2) begin
         n_err++; $display("FAIL right_first_latency got %0d steps want first at E2", nobs);
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (step_cyc_q[obs_base+i+1] - step_cyc_q[obs_base+i] != want_iv[i] ||
                step_val_q[obs_base+i] !== want_seq[i]) begin
               n_err++;
               $display("FAIL right_interval%0d got %0d steer %b want %0d steer %b", i,
                        step_cyc_q[obs_base+i+1] - step_cyc_q[obs_base+i], step_val_q[obs_base+i],
                        want_iv[i], want_seq[i]);
            end
         end
      end
      n_vec++;
      if (toggle_err != tog_base) begin
         n_err++; $display("FAIL single_bit_toggle got %0d bad steps want 0", toggle_err - tog_base);
      end
   endtask

   task automatic test_left_hold();
      logic [1:0] want_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      int nobs;
      do_reset();
      apply(2, 30);
      apply(0, 10);
      build_expected(SLOW, FAST, DEC);
      nobs = step_cyc_q.size() - obs_base;
      n_vec++;
      if (nobs != exp_cyc_q.size()) begin
         n_err++; $display("FAIL left_hold_count got %0d want %0d", nobs, exp_cyc_q.size());
      end
      for (int i = 0; i < exp_cyc_q.size() && i < nobs; i++) begin
         n_vec++;
         if (step_cyc_q[obs_base+i] != exp_cyc_q[i] || step_val_q[obs_base+i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL left_hold_step%0d got edge %0d steer %b want edge %0d steer %b", i,
                     step_cyc_q[obs_base+i], step_val_q[obs_base+i], exp_cyc_q[i], exp_q[i]);
         end
      end
      for (int i = 0; i < 4 && i < nobs; i++) begin
         n_vec++;
         if (step_val_q[obs_base+i] !== want_seq[i]) begin
            n_err++; $display("FAIL left_seq%0d got %b want %b", i, step_val_q[obs_base+i], want_seq[i]);
         end
      end
   endtask

   task automatic test_release_repress();
      int nobs;
      int rp;
      do_reset();
      apply(1, 16);
      apply(0, 10);
      n_vec++;
      if (steer !== 2'b10) begin n_err++; $display("FAIL release_hold_steer got %b want 10", steer); end
      n_vec++;
      if (moving !== 1'b0) begin n_err++; $display("FAIL release_moving got %b want 0", moving); end
      apply(1, 20);
      apply(0, 10);
      build_expected(SLOW, FAST, DEC);
      nobs = step_cyc_q.size() - obs_base;
      n_vec++;
      if (nobs != exp_cyc_q.size()) begin
         n_err++; $display("FAIL repress_count got %0d want %0d", nobs, exp_cyc_q.size());
      end
      for (int i = 0; i < exp_cyc_q.size() && i < nobs; i++) begin
         n_vec++;
         if (step_cyc_q[obs_base+i] != exp_cyc_q[i] || step_val_q[obs_base+i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL repress_step%0d got edge %0d steer %b want edge %0d steer %b", i,
                     step_cyc_q[obs_base+i], step_val_q[obs_base+i], exp_cyc_q[i], exp_q[i]);
         end
      end
      rp = seg_start[2] + 2;
      n_vec++;
      if (nobs < 5 || step_cyc_q[obs_base+3] != rp || step_val_q[obs_base+3] !== 2'b00 ||
          step_cyc_q[obs_base+4] != rp + 8) begin
         n_err++; $display("FAIL repress_restart got %0d steps want step to 00 at %0d then +8", nobs, rp);
      end
   endtask

   task automatic test_reversal();
      int nobs;
      int rv;
      do_reset();
      apply(1, 14);
      apply(2, 20);
      apply(0, 10);
      build_expected(SLOW, FAST, DEC);
      nobs = step_cyc_q.size() - obs_base;
      n_vec++;
      if (nobs != exp_cyc_q.size()) begin
         n_err++; $display("FAIL reversal_count got %0d want %0d", nobs, exp_cyc_q.size());
      end
      for (int i = 0; i < exp_cyc_q.size() && i < nobs; i++) begin
         n_vec++;
         if (step_cyc_q[obs_base+i] != exp_cyc_q[i] || step_val_q[obs_base+i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL reversal_step%0d got edge %0d steer %b want edge %0d steer %b", i,
                     step_cyc_q[obs_base+i], step_val_q[obs_base+i], exp_cyc_q[i], exp_q[i]);
         end
      end
      rv = seg_start[1] + 2;
      n_vec++;
      if (nobs < 4 || step_cyc_q[obs_base+2] != rv || step_val_q[obs_base+2] !== 2'b01 ||
          step_cyc_q[obs_base+3] != rv + 8 || step_val_q[obs_base+3] !== 2'b00) begin
         n_err++; $display("FAIL reversal_single_step got %0d steps want 01 at %0d then 00 at %0d", nobs, rv, rv + 8);
      end
   endtask

   task automatic test_both();
      int nobs;
      do_reset();
      apply(1, 20);
      apply(3, 3);
      n_vec++;
      if (moving !== 1'b0) begin n_err++; $display("FAIL both_moving got %b want 0", moving); end
      n_vec++;
      if (steer !== 2'b00) begin n_err++; $display("FAIL both_steer_hold got %b want 00", steer); end
      apply(3, 7);
      n_vec++;
      if (steer !== 2'b00) begin n_err++; $display("FAIL both_steer_hold_late got %b want 00", steer); end
      apply(0, 5);
      build_expected(SLOW, FAST, DEC);
      nobs = step_cyc_q.size() - obs_base;
      n_vec++;
      if (nobs != exp_cyc_q.size()) begin
         n_err++; $display("FAIL both_count got %0d want %0d", nobs, exp_cyc_q.size());
      end
      for (int i = 0; i < exp_cyc_q.size() && i < nobs; i++) begin
         n_vec++;
         if (step_cyc_q[obs_base+i] != exp_cyc_q[i] || step_val_q[obs_base+i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL both_step%0d got edge %0d steer %b want edge %0d steer %b", i,
                     step_cyc_q[obs_base+i], step_val_q[obs_base+i], exp_cyc_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random(input int round);
      int nobs;
      int d;
      int eff;
      int prev_eff;
      do_reset();
      prev_eff = 0;
      for (int s = 0; s < 14; s++) begin
         d   = $urandom_range(0, 3);
         eff = (d == 1) ? 1 : ((d == 2) ? -1 : 0);
         for (int tries = 0; tries < 50 && eff == prev_eff; tries++) begin
            d   = $urandom_range(0, 3);
            eff = (d == 1) ? 1 : ((d == 2) ? -1 : 0);
         end
         if (eff == prev_eff) begin
            d   = (prev_eff == 1) ? 2 : 1;
            eff = (d == 1) ? 1 : -1;
         end
         apply(d, $urandom_range(3, 25));
         n_vec++;
         if (moving !== (eff != 0)) begin
            n_err++; $display("FAIL random%0d_moving seg%0d got %b want %b", round, s, moving, eff != 0);
         end
         prev_eff = eff;
      end
      apply(0, 12);
      build_expected(SLOW, FAST, DEC);
      nobs = step_cyc_q.size() - obs_base;
      n_vec++;
      if (nobs != exp_cyc_q.size()) begin
         n_err++; $display("FAIL random%0d_count got %0d want %0d", round, nobs, exp_cyc_q.size());
      end
      for (int i = 0; i < exp_cyc_q.size() && i < nobs; i++) begin
         n_vec++;
         if (step_cyc_q[obs_base+i] != exp_cyc_q[i] || step_val_q[obs_base+i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL random%0d_step%0d got edge %0d steer %b want edge %0d steer %b", round, i,
                     step_cyc_q[obs_base+i], step_val_q[obs_base+i], exp_cyc_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (toggle_err != tog_base) begin
         n_err++; $display("FAIL random%0d_toggle got %0d bad steps want 0", round, toggle_err - tog_base);
      end
   endtask

   task automatic test_ramp_scaled();
      int st[$];
      int want;
      do_reset();
      right2 = 1'b1;
      for (int i = 0; i < 6000 && st.size() < 18; i++) begin
         @(negedge clk);
         if (step_pulse2 === 1'b1) st.push_back(cyc);
      end
      right2 = 1'b0;
      n_vec++;
      if (st.size() != 18) begin
         n_err++; $display("FAIL ramp_scaled_count got %0d want 18", st.size());
      end
      for (int k = 0; k < 17 && k + 1 < st.size(); k++) begin
         want = S2 - k * D2;
         if (want < F2) want = F2;
         n_vec++;
         if (st[k+1] - st[k] != want) begin
            n_err++; $display("FAIL ramp_scaled_interval%0d got %0d want %0d", k + 1, st[k+1] - st[k], want);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_defaults();
      int st[$];
      int s0;
      do_reset();
      right3 = 1'b1;
      s0 = cyc + 1;
      for (int i = 0; i < 23000 && st.size() < 2; i++) begin
         @(negedge clk);
         if (step_pulse3 === 1'b1) begin
            st.push_back(cyc);
            if (st.size() == 1) begin
               n_vec++;
               if (steer3 !== 2'b01) begin n_err++; $display("FAIL default_first_steer got %b want 01", steer3); end
            end
         end
      end
      right3 = 1'b0;
      n_vec++;
      if (st.size() != 2) begin
         n_err++; $display("FAIL default_count got %0d want 2", st.size());
      end else begin
         n_vec++;
         if (st[0] != s0 + 2) begin n_err++; $display("FAIL default_latency got %0d want %0d", st[0] - s0, 2); end
         n_vec++;
         if (st[1] - st[0] != 22500) begin
            n_err++; $display("FAIL default_first_interval got %0d want 22500", st[1] - st[0]);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      right  = 1'b0;
      left   = 1'b0;
      right2 = 1'b0;
      left2  = 1'b0;
      right3 = 1'b0;
      left3  = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_right_hold();
      test_left_hold();
      test_release_repress();
      test_reversal();
      test_both();
      test_random(0);
      test_random(1);
      test_random(2);
      test_ramp_scaled();
      test_defaults();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/steer_quad_gen.md
# steer_quad_gen

Generates the two-phase quadrature steering signal for the Sprint 1 core from digital joystick left/right inputs. It sits between the joystick bits decoded from `hps_io` and the core's `SteerA_I`/`SteerB_I` inputs, and runs on the core's 6 MHz video clock. Holding a direction produces quadrature steps at an accelerating rate, which emulates a spun steering wheel. Opposite or absent input holds the encoder position.

## Interface
Parameters:
- `DIV_SLOW`, default 22500: step interval in clocks for the first interval after a press.
- `DIV_FAST`, default 5625: minimum step interval in clocks, reached after ramping.
- `DIV_DEC`, default 1125: interval reduction applied after each step. 0 disables the ramp.
- `CW`, default `$clog2(DIV_SLOW+1)`: width of the interval counter and period register.

Ports:
- `CLK` in 1: the single clock, the core's 6 MHz `clk_6` domain.
- `reset` in 1: synchronous, active-high reset.
- `left` in 1: joystick left, asynchronous to `CLK`.
- `right` in 1: joystick right, asynchronous to `CLK`.
- `steer` out 2: quadrature output. `steer[1]` drives `SteerA_I` and `steer[0]` drives `SteerB_I`.
- `moving` out 1: high while the FSM is in RUN_R or RUN_L.
- `step_pulse` out 1: high for one cycle on every quadrature transition.

Elaboration constraints:
- 1 ≤ `DIV_FAST` ≤ `DIV_SLOW`.
- `DIV_DEC` < `DIV_SLOW`.
- Any violation is flagged with an elaboration `$error`.

## Operation
Input synchronisation:
- `left` and `right` each pass through a 2-flop synchronizer, giving `l_s` and `r_s`.
- `dir_req` is R when `r_s & ~l_s`, L when `l_s & ~r_s`, otherwise NONE. Both pressed counts as NONE.

FSM states are IDLE, RUN_R and RUN_L.
- IDLE → RUN_R or RUN_L on the matching `dir_req`. Entry counts as a "start".
- RUN_x → IDLE when `dir_req` = NONE. The phase is held, `cnt` is cleared and `period` is set to `DIV_SLOW`.
- RUN_R ↔ RUN_L on a reversed `dir_req`. This also counts as a "start", with no IDLE cycle in between.

On every start:
- One step is issued in the same cycle.
- `period` is set to `DIV_SLOW`.
- `cnt` is loaded with `DIV_SLOW-1`.

While in RUN_x with no state change:
- If `cnt` ≠ 0, `cnt` decrements.
- If `cnt` = 0, a step is issued, `cnt` is loaded with `nxt-1` and `period` becomes `nxt`.
- `nxt` = max(`period` − `DIV_DEC`, `DIV_FAST`). Compute it in CW+1 bits so the subtraction cannot wrap.

Each step moves a 2-bit phase:
- RUN_R increments it by 1 (mod 4). RUN_L decrements it by 1 (mod 4).
- `steer` is the Gray code of the phase: 0→00, 1→01, 2→11, 3→10.
- Right therefore walks `steer` through 00→01→11→10→00. Left walks the reverse sequence.
- Exactly one bit of `steer` changes per step, and `step_pulse` is asserted for that cycle.

Reset:
- Applies in any state, including mid-interval.
- Clears the synchronizers, FSM (IDLE), phase, `cnt` and `step_pulse` to 0, and sets `period` to `DIV_SLOW`.
- Output reset values: `steer` = 00, `moving` = 0, `step_pulse` = 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Press latency: with `right` high at edge E0, `l_s`/`r_s` settle at E1. At E2 the FSM enters RUN_R, `steer` advances and `step_pulse` goes high for the cycle following E2.
- Inter-step intervals, measured edge to edge between steps:
  - first interval is `DIV_SLOW`;
  - then `DIV_SLOW−DIV_DEC`, `DIV_SLOW−2·DIV_DEC`, and so on;
  - clamped at `DIV_FAST`.
- With the defaults the ramp reaches 5625 after 15 intervals and stays there.
- Release latency: with input low at edge E0, `moving` goes low at E2. A step scheduled for E2 is suppressed.
- A reversal at the same edge as `cnt` = 0 is treated as a start: one step in the new direction, never two steps.
- A pulse shorter than 2 clocks may be missed. This is acceptable.

## Test plan
All scenarios use `DIV_SLOW`=8, `DIV_FAST`=4, `DIV_DEC`=2 unless stated.
- Reset: assert `reset` mid-run with `steer`=11 → next cycle `steer`=00, `moving`=0, `step_pulse`=0. With `right` still held after `reset` drops, the first step follows 3 edges later.
- Right hold: `right`=1 for 40 clocks → `steer` sequence 01,11,10,00,01… Steps occur at E2, E2+8, +6, +4, +4, +4. Every `step_pulse` coincides with exactly one `steer` bit toggle.
- Left hold from reset → `steer` sequence 10,11,01,00 with the same interval sequence 8,6,4.
- Release and re-press: hold `right` for 3 steps, release for 10 clocks → `steer` stays 10 and `moving`=0. Re-press → immediate step to 00, and the interval restarts at 8.
- Reversal: switch `right`→`left` exactly on the cycle where `cnt`=0 → a single step backward, the interval restarts at 8, and no extra forward step occurs.
- Both pressed during RUN_R → `moving`=0 within 2 cycles and `steer` holds. With defaults (22500/5625/1125) and `right` held, the 17th interval measures exactly 5625 clocks.
